// File: rtl/softusb_rx_pkg.sv
// Shared types and constants for the USB 1.1 receive front end.
package softusb_rx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StRecv,
    StEop,
    StErr
  } rx_state_e;

  localparam logic [7:0]  SyncPattern  = 8'h80;
  localparam int unsigned StuffLimit   = 6;
  localparam int unsigned ErrIdleBits  = 8;
  localparam int unsigned FsDivDefault = 4;
  localparam int unsigned LsDivDefault = 32;

endpackage

// File: rtl/softusb_rx_dpll.sv
// Input synchronizers, J/K/SE0 line-state decode and mid-bit sample strobe generation.
module softusb_rx_dpll
  import softusb_rx_pkg::*;
#(
  parameter int unsigned fs_div = FsDivDefault,
  parameter int unsigned ls_div = LsDivDefault
) (
  input  logic usb_clk,
  input  logic usb_rst,
  input  logic low_speed,
  input  logic rx,
  input  logic rxp,
  input  logic rxm,
  output logic strobe,
  output logic j,
  output logic k,
  output logic se0
);

  localparam int unsigned MaxDiv = (ls_div > fs_div) ? ls_div : fs_div;
  localparam int unsigned PhaseW = $clog2(MaxDiv);
  localparam logic [PhaseW-1:0] FsWrap = PhaseW'(fs_div - 1);
  localparam logic [PhaseW-1:0] LsWrap = PhaseW'(ls_div - 1);
  localparam logic [PhaseW-1:0] FsHalf = PhaseW'(fs_div / 2);
  localparam logic [PhaseW-1:0] LsHalf = PhaseW'(ls_div / 2);

  logic              rx_meta, rx_s, rx_last;
  logic              rxp_meta, rxp_s;
  logic              rxm_meta, rxm_s;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic [PhaseW-1:0] wrap, half;

  always_ff @(posedge usb_clk) begin
    if (usb_rst) begin
      rx_meta  <= 1'b0;
      rx_s     <= 1'b0;
      rx_last  <= 1'b0;
      rxp_meta <= 1'b0;
      rxp_s    <= 1'b0;
      rxm_meta <= 1'b0;
      rxm_s    <= 1'b0;
      phase_q  <= '0;
    end else begin
      rx_meta  <= rx;
      rx_s     <= rx_meta;
      rx_last  <= rx_s;
      rxp_meta <= rxp;
      rxp_s    <= rxp_meta;
      rxm_meta <= rxm;
      rxm_s    <= rxm_meta;
      phase_q  <= phase_d;
    end
  end

  // Every transition on the differential line re-centres the bit phase.
  always_comb begin
    wrap = low_speed ? LsWrap : FsWrap;
    half = low_speed ? LsHalf : FsHalf;
    if (rx_s != rx_last) begin
      phase_d = PhaseW'(1);
    end else if (phase_q == wrap) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + 1'b1;
    end
  end

  assign strobe = (phase_q == half);
  assign se0    = ~rxp_s & ~rxm_s;
  // Low speed swaps J/K polarity on the differential receiver.
  assign j      = ~se0 & (rx_s != low_speed);
  assign k      = ~se0 & (rx_s == low_speed);

endmodule

// File: rtl/softusb_rx.sv
// USB 1.1 receive front end: SYNC/EOP detection, NRZI decode, destuffing and byte assembly.
module softusb_rx
  import softusb_rx_pkg::*;
#(
  parameter int unsigned fs_div = FsDivDefault,
  parameter int unsigned ls_div = LsDivDefault
) (
  input  logic       usb_clk,
  input  logic       usb_rst,
  input  logic       rxreset,
  input  logic       low_speed,
  input  logic       rx,
  input  logic       rxp,
  input  logic       rxm,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_error
);

  rx_state_e  state_q, state_d;
  logic       ls_q, ls_d;
  logic       prev_j_q, prev_j_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] ones_q, ones_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] idle_cnt_q, idle_cnt_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       error_q, error_d;

  logic       strobe, j, k, se0;
  logic       dec;
  logic [7:0] shift_in;

  softusb_rx_dpll #(
    .fs_div (fs_div),
    .ls_div (ls_div)
  ) u_dpll (
    .usb_clk   (usb_clk),
    .usb_rst   (usb_rst),
    .low_speed (ls_q),
    .rx        (rx),
    .rxp       (rxp),
    .rxm       (rxm),
    .strobe    (strobe),
    .j         (j),
    .k         (k),
    .se0       (se0)
  );

  // NRZI: an unchanged level is a 1.
  assign dec      = (j == prev_j_q);
  assign shift_in = {dec, shift_q[7:1]};

  always_comb begin
    state_d    = state_q;
    ls_d       = ls_q;
    prev_j_d   = prev_j_q;
    shift_d    = shift_q;
    ones_d     = ones_q;
    bit_cnt_d  = bit_cnt_q;
    idle_cnt_d = idle_cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    error_d    = 1'b0;

    if (strobe) begin
      prev_j_d = j;
    end

    unique case (state_q)
      StIdle: begin
        ls_d = low_speed;
        if (strobe && k) begin
          state_d = StSync;
          shift_d = '0;
        end
      end

      StSync: begin
        if (strobe) begin
          if (se0) begin
            state_d = StIdle;
          end else begin
            shift_d = shift_in;
            if (shift_in == SyncPattern) begin
              state_d   = StRecv;
              ones_d    = 3'd1;
              bit_cnt_d = '0;
            end
          end
        end
      end

      StRecv: begin
        if (strobe) begin
          if (se0) begin
            state_d = StEop;
            ones_d  = '0;
            error_d = (bit_cnt_q != '0);
          end else if (ones_q == 3'(StuffLimit)) begin
            ones_d = '0;
            if (dec) begin
              error_d    = 1'b1;
              state_d    = StErr;
              idle_cnt_d = '0;
            end
          end else begin
            ones_d    = dec ? ones_q + 3'd1 : 3'd0;
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              data_d  = shift_in;
              valid_d = 1'b1;
            end
          end
        end
      end

      StEop: begin
        if (strobe) begin
          if (j) begin
            state_d = StIdle;
          end else if (k) begin
            error_d    = 1'b1;
            state_d    = StErr;
            idle_cnt_d = '0;
          end
        end
      end

      StErr: begin
        if (strobe) begin
          if (!j) begin
            idle_cnt_d = '0;
          end else if (idle_cnt_q == 4'(ErrIdleBits - 1)) begin
            idle_cnt_d = '0;
            state_d    = StIdle;
          end else begin
            idle_cnt_d = idle_cnt_q + 4'd1;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    // Abort drops any partial byte and suppresses this cycle's strobes.
    if (rxreset) begin
      state_d    = StIdle;
      valid_d    = 1'b0;
      error_d    = 1'b0;
      data_d     = '0;
      idle_cnt_d = '0;
    end
  end

  always_ff @(posedge usb_clk) begin
    if (usb_rst) begin
      state_q    <= StIdle;
      ls_q       <= 1'b0;
      prev_j_q   <= 1'b1;
      shift_q    <= '0;
      ones_q     <= '0;
      bit_cnt_q  <= '0;
      idle_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ls_q       <= ls_d;
      prev_j_q   <= prev_j_d;
      shift_q    <= shift_d;
      ones_q     <= ones_d;
      bit_cnt_q  <= bit_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_error  = error_q;
  assign rx_active = (state_q == StRecv) || (state_q == StEop);

endmodule

// File: tb/tb_softusb_rx.sv
// Bench: line-level packet generator (stuffing + NRZI + jitter) against a byte/error model.
module tb_softusb_rx;

  logic       usb_clk = 1'b0;
  logic       usb_rst, rxreset, low_speed, rx, rxp, rxm;
  logic [7:0] rx_data;
  logic       rx_valid, rx_active, rx_error;

  softusb_rx dut (
    .usb_clk   (usb_clk),
    .usb_rst   (usb_rst),
    .rxreset   (rxreset),
    .low_speed (low_speed),
    .rx        (rx),
    .rxp       (rxp),
    .rxm       (rxm),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_active (rx_active),
    .rx_error  (rx_error)
  );

  always #5 usb_clk = ~usb_clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] got_q[$];
  logic [7:0] tx_bytes[$];
  int         sym_q[$];     // 0 = J, 1 = K, 2 = SE0
  int         err_seen = 0;
  int         both_seen = 0;
  int         active_cycles = 0;
  bit         cur_ls = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge usb_clk) begin
    if (rx_valid === 1'b1) got_q.push_back(rx_data);
    if (rx_error === 1'b1) err_seen++;
    if (rx_valid === 1'b1 && rx_error === 1'b1) both_seen++;
    if (rx_active === 1'b1) active_cycles++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic set_line(input int s);
    case (s)
      0: begin rx = cur_ls ? 1'b0 : 1'b1; rxp = rx; rxm = ~rx; end
      1: begin rx = cur_ls ? 1'b1 : 1'b0; rxp = rx; rxm = ~rx; end
      default: begin rxp = 1'b0; rxm = 1'b0; end
    endcase
  endtask

  // Bit boundaries sit at ideal position plus a per-boundary offset, so jitter never accumulates.
  task automatic drive_syms(input int count);
    int div, jlo, jhi, jc, jn, dur;
    div = cur_ls ? 32 : 4;
    jlo = cur_ls ? -3 : 0;
    jhi = cur_ls ? 3 : 1;
    jc  = 0;
    for (int i = 0; i < count && i < sym_q.size(); i++) begin
      set_line(sym_q[i]);
      jn  = (i == count - 1) ? 0 : jlo + int'($urandom_range(0, jhi - jlo));
      dur = div + jn - jc;
      repeat (dur) @(negedge usb_clk);
      jc = jn;
    end
  endtask

  // Reference: USB bit stuffing counts from the final SYNC 1; a packet
  // yields every fully transmitted byte, and an error for a short final
  // byte or a corrupted stuff bit.
  task automatic build_packet(input int trunc_bits, input bit bad_stuff,
                              output int exp_bytes, output int exp_err);
    bit dec_q[$];
    int ones, nbits, lvl;
    bit hit, b;
    dec_q.delete();
    sym_q.delete();
    for (int i = 0; i < 7; i++) dec_q.push_back(1'b0);
    dec_q.push_back(1'b1);
    ones  = 1;
    nbits = (trunc_bits >= 0) ? trunc_bits : tx_bytes.size() * 8;
    exp_bytes = nbits / 8;
    exp_err   = (nbits % 8 != 0) ? 1 : 0;
    hit = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      b = tx_bytes[i / 8][i % 8];
      dec_q.push_back(b);
      ones = b ? ones + 1 : 0;
      if (ones == 6) begin
        if (bad_stuff && !hit) begin
          dec_q.push_back(1'b1);
          hit = 1'b1;
          exp_bytes = (i + 1) / 8;
          exp_err   = 1;
        end else begin
          dec_q.push_back(1'b0);
        end
        ones = 0;
      end
    end
    lvl = 0;
    foreach (dec_q[i]) begin
      if (!dec_q[i]) lvl = 1 - lvl;
      sym_q.push_back(lvl);
    end
    sym_q.push_back(2);
    sym_q.push_back(2);
    for (int i = 0; i < 13; i++) sym_q.push_back(0);
  endtask

  task automatic run_packet(input string tag, input int trunc_bits, input bit bad_stuff);
    int exp_bytes, exp_err, base, e0, a0;
    build_packet(trunc_bits, bad_stuff, exp_bytes, exp_err);
    base = got_q.size();
    e0   = err_seen;
    a0   = active_cycles;
    drive_syms(sym_q.size());
    repeat (4) @(negedge usb_clk);
    check_eq({tag, "_nbytes"}, got_q.size() - base, exp_bytes);
    for (int i = 0; i < exp_bytes && base + i < got_q.size(); i++)
      check_eq({tag, "_byte"}, got_q[base + i], tx_bytes[i]);
    check_eq({tag, "_errs"}, err_seen - e0, exp_err);
    check_eq({tag, "_active_seen"}, active_cycles > a0, 1);
    check_eq({tag, "_active_end"}, rx_active, 0);
  endtask

  task automatic set_speed(input bit ls);
    set_line(2);
    repeat (8) @(negedge usb_clk);
    low_speed = ls;
    cur_ls    = ls;
    repeat (4) @(negedge usb_clk);
    set_line(0);
    repeat (4 * (ls ? 32 : 4)) @(negedge usb_clk);
  endtask

  task automatic load_bytes2(input logic [7:0] a, input logic [7:0] b);
    tx_bytes.delete();
    tx_bytes.push_back(a);
    tx_bytes.push_back(b);
  endtask

  initial begin
    int exp_b, exp_e, cnt, base, e0, n, trunc;
    bit ls;
    usb_rst   = 1'b1;
    rxreset   = 1'b0;
    low_speed = 1'b0;
    set_line(0);
    repeat (5) @(negedge usb_clk);
    check_eq("rst_data", rx_data, 0);
    check_eq("rst_valid", rx_valid, 0);
    check_eq("rst_active", rx_active, 0);
    check_eq("rst_error", rx_error, 0);
    usb_rst = 1'b0;
    repeat (20) @(negedge usb_clk);

    load_bytes2(8'hA5, 8'h3C);
    run_packet("fs_a5_3c", -1, 1'b0);

    load_bytes2(8'hFF, 8'h01);
    run_packet("stuff_ok", -1, 1'b0);
    run_packet("stuff_bad", -1, 1'b1);
    run_packet("after_stuff_bad", -1, 1'b0);

    load_bytes2(8'hA5, 8'h3C);
    run_packet("trunc13", 13, 1'b0);

    // Abort mid-second-byte while the line is at J.
    load_bytes2(8'h5A, 8'hC3);
    build_packet(-1, 1'b0, exp_b, exp_e);
    cnt = 20;
    while (sym_q[cnt - 1] != 0) cnt++;
    base = got_q.size();
    e0   = err_seen;
    drive_syms(cnt);
    rxreset = 1'b1;
    set_line(0);
    @(negedge usb_clk);
    check_eq("rxreset_active", rx_active, 0);
    check_eq("rxreset_valid", rx_valid, 0);
    rxreset = 1'b0;
    repeat (60) @(negedge usb_clk);
    check_eq("rxreset_nbytes", got_q.size() - base, 1);
    check_eq("rxreset_errs", err_seen - e0, 0);
    run_packet("after_rxreset", -1, 1'b0);

    set_speed(1'b1);
    tx_bytes.delete();
    tx_bytes.push_back(8'h69);
    run_packet("ls_69", -1, 1'b0);

    for (int p = 0; p < 8; p++) begin
      ls = ($urandom_range(0, 3) == 0);
      if (ls != cur_ls) set_speed(ls);
      n = $urandom_range(1, 3);
      tx_bytes.delete();
      for (int i = 0; i < n; i++)
        tx_bytes.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      trunc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, n * 8 - 1)) : -1;
      run_packet("rand", trunc, 1'b0);
    end

    check_eq("valid_error_overlap", both_seen, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
